// File: rtl/issue_queue.sv
// N_WAY-wide out-of-order issue queue: age-ordered select, tag wakeup from the CDB, flush and free-slot tracking.
// Define IQ_EARLY_WAKEUP_EN to also wake sources from the execute-stage ex_valid/ex_tag bus.
module issue_queue #(
   parameter int N_WAY     = 3,
   parameter int N_ENTRIES = 16,
   parameter int TAG_BITS  = 6,
   parameter int INST_BITS = 32
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [N_WAY-1:0]               disp_valid,
   input  logic [N_WAY*INST_BITS-1:0]     disp_inst,
   input  logic [N_WAY*TAG_BITS-1:0]      disp_dest_tag,
   input  logic [N_WAY*TAG_BITS-1:0]      disp_src1_tag,
   input  logic [N_WAY-1:0]               disp_src1_ready,
   input  logic [N_WAY*TAG_BITS-1:0]      disp_src2_tag,
   input  logic [N_WAY-1:0]               disp_src2_ready,
   input  logic [N_WAY-1:0]               cdb_valid,
   input  logic [N_WAY*TAG_BITS-1:0]      cdb_tag,
   input  logic [N_WAY-1:0]               ex_valid,
   input  logic [N_WAY*TAG_BITS-1:0]      ex_tag,
   input  logic [N_WAY-1:0]               fu_ready,
   input  logic                           flush,
   output logic [N_WAY-1:0]               issue_valid,
   output logic [N_WAY*INST_BITS-1:0]     issue_inst,
   output logic [N_WAY*TAG_BITS-1:0]      issue_dest_tag,
   output logic [N_WAY*TAG_BITS-1:0]      issue_src1_tag,
   output logic [N_WAY*TAG_BITS-1:0]      issue_src2_tag,
   output logic [$clog2(N_ENTRIES+1)-1:0] free_count,
   output logic                           disp_stall
);

   localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int CNT_W = $clog2(N_ENTRIES + 1);

`ifdef IQ_EARLY_WAKEUP_EN
   localparam int N_WAKE = 2 * N_WAY;
`else
   localparam int N_WAKE = N_WAY;
`endif

   logic [N_WAKE-1:0]          wake_v;
   logic [N_WAKE*TAG_BITS-1:0] wake_t;

`ifdef IQ_EARLY_WAKEUP_EN
   assign wake_v = {ex_valid, cdb_valid};
   assign wake_t = {ex_tag, cdb_tag};
`else
   logic unused_ex;
   assign wake_v    = cdb_valid;
   assign wake_t    = cdb_tag;
   assign unused_ex = ^{ex_valid, ex_tag};
`endif

   logic [N_ENTRIES-1:0] valid_q, valid_d;
   logic [N_ENTRIES-1:0] s1_rdy_q, s1_rdy_d;
   logic [N_ENTRIES-1:0] s2_rdy_q, s2_rdy_d;
   // older_q[i][j] is set when entry i was dispatched before entry j
   logic [N_ENTRIES-1:0] older_q [N_ENTRIES];
   logic [N_ENTRIES-1:0] older_d [N_ENTRIES];
   logic [CNT_W-1:0]     free_count_q, free_count_d;

   logic [INST_BITS-1:0] inst_q   [N_ENTRIES];
   logic [TAG_BITS-1:0]  dest_q   [N_ENTRIES];
   logic [TAG_BITS-1:0]  s1_tag_q [N_ENTRIES];
   logic [TAG_BITS-1:0]  s2_tag_q [N_ENTRIES];

   logic                 accept;
   logic [N_WAY-1:0]     alloc_vld;
   logic [IDX_W-1:0]     alloc_ent [N_WAY];
   logic [N_ENTRIES-1:0] issuable;
   logic [N_ENTRIES-1:0] issued;
   logic [CNT_W-1:0]     rank [N_ENTRIES];

   function automatic logic tag_hit(input logic [TAG_BITS-1:0]        tag,
                                    input logic [N_WAKE-1:0]          v,
                                    input logic [N_WAKE*TAG_BITS-1:0] t);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < N_WAKE; j++) begin
         if (v[j] && (t[j*TAG_BITS +: TAG_BITS] == tag)) hit = 1'b1;
      end
      return hit;
   endfunction

   assign free_count = free_count_q;
   assign disp_stall = (free_count_q < CNT_W'(N_WAY));

   // Lane k that is the m-th valid lane takes the m-th lowest-index free entry.
   always_comb begin : p_alloc
      int m;
      int fr;
      accept    = ~disp_stall & ~flush;
      alloc_vld = disp_valid & {N_WAY{accept}};
      m         = 0;
      for (int k = 0; k < N_WAY; k++) begin
         alloc_ent[k] = '0;
         fr = 0;
         for (int e = 0; e < N_ENTRIES; e++) begin
            if (!valid_q[e]) begin
               if (fr == m) alloc_ent[k] = IDX_W'(e);
               fr++;
            end
         end
         if (disp_valid[k]) m++;
      end
   end

   // An entry's rank is the number of issuable entries older than it.
   always_comb begin : p_rank
      issuable = valid_q & s1_rdy_q & s2_rdy_q & {N_ENTRIES{~flush}};
      for (int e = 0; e < N_ENTRIES; e++) begin
         rank[e] = '0;
         for (int x = 0; x < N_ENTRIES; x++) begin
            if (issuable[x] && older_q[x][e]) rank[e] = rank[e] + CNT_W'(1);
         end
      end
   end

   always_comb begin : p_select
      int pos;
      issue_valid    = '0;
      issue_inst     = '0;
      issue_dest_tag = '0;
      issue_src1_tag = '0;
      issue_src2_tag = '0;
      issued         = '0;
      pos            = 0;
      for (int k = 0; k < N_WAY; k++) begin
         if (fu_ready[k]) begin
            for (int e = 0; e < N_ENTRIES; e++) begin
               if (issuable[e] && (int'(rank[e]) == pos)) begin
                  issue_valid[k]                          = 1'b1;
                  issued[e]                               = 1'b1;
                  issue_inst[k*INST_BITS +: INST_BITS]    = inst_q[e];
                  issue_dest_tag[k*TAG_BITS +: TAG_BITS]  = dest_q[e];
                  issue_src1_tag[k*TAG_BITS +: TAG_BITS]  = s1_tag_q[e];
                  issue_src2_tag[k*TAG_BITS +: TAG_BITS]  = s2_tag_q[e];
               end
            end
            pos++;
         end
      end
   end

   always_comb begin : p_next
      valid_d  = valid_q & ~issued;
      s1_rdy_d = s1_rdy_q;
      s2_rdy_d = s2_rdy_q;
      older_d  = older_q;
      for (int e = 0; e < N_ENTRIES; e++) begin
         if (tag_hit(s1_tag_q[e], wake_v, wake_t)) s1_rdy_d[e] = 1'b1;
         if (tag_hit(s2_tag_q[e], wake_v, wake_t)) s2_rdy_d[e] = 1'b1;
      end
      // Lanes are processed in order so later lanes end up younger than earlier ones.
      for (int k = 0; k < N_WAY; k++) begin
         if (alloc_vld[k]) begin
            valid_d[alloc_ent[k]]  = 1'b1;
            s1_rdy_d[alloc_ent[k]] = disp_src1_ready[k] |
                                     tag_hit(disp_src1_tag[k*TAG_BITS +: TAG_BITS], wake_v, wake_t);
            s2_rdy_d[alloc_ent[k]] = disp_src2_ready[k] |
                                     tag_hit(disp_src2_tag[k*TAG_BITS +: TAG_BITS], wake_v, wake_t);
            older_d[alloc_ent[k]]  = '0;
            for (int x = 0; x < N_ENTRIES; x++) begin
               if (x != int'(alloc_ent[k])) older_d[x][alloc_ent[k]] = 1'b1;
            end
         end
      end
      if (flush) valid_d = '0;
   end

   always_comb begin : p_count
      int n_acc;
      int n_iss;
      n_acc = 0;
      n_iss = 0;
      for (int k = 0; k < N_WAY; k++) begin
         if (alloc_vld[k])   n_acc++;
         if (issue_valid[k]) n_iss++;
      end
      if (flush) free_count_d = CNT_W'(N_ENTRIES);
      else       free_count_d = CNT_W'(int'(free_count_q) - n_acc + n_iss);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q      <= '0;
         s1_rdy_q     <= '0;
         s2_rdy_q     <= '0;
         older_q      <= '{default: '0};
         free_count_q <= CNT_W'(N_ENTRIES);
      end else begin
         valid_q      <= valid_d;
         s1_rdy_q     <= s1_rdy_d;
         s2_rdy_q     <= s2_rdy_d;
         older_q      <= older_d;
         free_count_q <= free_count_d;
      end
   end

   // Payload is qualified by valid_q, so it carries no reset.
   always_ff @(posedge clock) begin
      for (int k = 0; k < N_WAY; k++) begin
         if (alloc_vld[k]) begin
            inst_q[alloc_ent[k]]   <= disp_inst[k*INST_BITS +: INST_BITS];
            dest_q[alloc_ent[k]]   <= disp_dest_tag[k*TAG_BITS +: TAG_BITS];
            s1_tag_q[alloc_ent[k]] <= disp_src1_tag[k*TAG_BITS +: TAG_BITS];
            s2_tag_q[alloc_ent[k]] <= disp_src2_tag[k*TAG_BITS +: TAG_BITS];
         end
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized self-checking bench for issue_queue against an age-ordered queue model.
module tb_issue_queue;
   localparam int NW = 3;
   localparam int NE = 16;
   localparam int TB = 6;
   localparam int IB = 32;

   logic              clock = 1'b0;
   logic              reset;
   logic [NW-1:0]     disp_valid;
   logic [NW*IB-1:0]  disp_inst;
   logic [NW*TB-1:0]  disp_dest_tag, disp_src1_tag, disp_src2_tag;
   logic [NW-1:0]     disp_src1_ready, disp_src2_ready;
   logic [NW-1:0]     cdb_valid, ex_valid, fu_ready;
   logic [NW*TB-1:0]  cdb_tag, ex_tag;
   logic              flush;
   logic [NW-1:0]     issue_valid;
   logic [NW*IB-1:0]  issue_inst;
   logic [NW*TB-1:0]  issue_dest_tag, issue_src1_tag, issue_src2_tag;
   logic [4:0]        free_count;
   logic              disp_stall;

   issue_queue #(.N_WAY(NW), .N_ENTRIES(NE), .TAG_BITS(TB), .INST_BITS(IB)) dut (
      .clock(clock), .reset(reset),
      .disp_valid(disp_valid), .disp_inst(disp_inst), .disp_dest_tag(disp_dest_tag),
      .disp_src1_tag(disp_src1_tag), .disp_src1_ready(disp_src1_ready),
      .disp_src2_tag(disp_src2_tag), .disp_src2_ready(disp_src2_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .ex_valid(ex_valid), .ex_tag(ex_tag),
      .fu_ready(fu_ready), .flush(flush),
      .issue_valid(issue_valid), .issue_inst(issue_inst), .issue_dest_tag(issue_dest_tag),
      .issue_src1_tag(issue_src1_tag), .issue_src2_tag(issue_src2_tag),
      .free_count(free_count), .disp_stall(disp_stall)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: entries held oldest-first; position in the queue is the age.
   typedef struct {
      logic [IB-1:0] inst;
      logic [TB-1:0] dest;
      logic [TB-1:0] s1;
      logic [TB-1:0] s2;
      bit            r1;
      bit            r2;
   } ent_t;

   ent_t mq[$];

   function automatic bit woken(input logic [TB-1:0] tag);
      for (int j = 0; j < NW; j++) begin
         if (cdb_valid[j] && cdb_tag[j*TB +: TB] == tag) return 1'b1;
`ifdef IQ_EARLY_WAKEUP_EN
         if (ex_valid[j] && ex_tag[j*TB +: TB] == tag) return 1'b1;
`endif
      end
      return 1'b0;
   endfunction

   task automatic model_step();
      logic [NW-1:0] ev;
      int            pick[NW];
      int            k;
      int            nfree;
      bit            iss;
      ent_t          e;
      ent_t          nq[$];
      ev = '0;
      k  = 0;
      for (int l = 0; l < NW; l++) pick[l] = -1;
      if (!flush) begin
         for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
               while (k < NW && !fu_ready[k]) k++;
               if (k < NW) begin
                  ev[k] = 1'b1;
                  pick[k] = i;
                  k++;
               end
            end
         end
      end
      nfree = NE - mq.size();
      check_eq("issue_valid", 64'(issue_valid), 64'(ev));
      for (int l = 0; l < NW; l++) begin
         if (ev[l]) begin
            check_eq("issue_inst", 64'(issue_inst[l*IB +: IB]), 64'(mq[pick[l]].inst));
            check_eq("issue_dest", 64'(issue_dest_tag[l*TB +: TB]), 64'(mq[pick[l]].dest));
            check_eq("issue_src1", 64'(issue_src1_tag[l*TB +: TB]), 64'(mq[pick[l]].s1));
            check_eq("issue_src2", 64'(issue_src2_tag[l*TB +: TB]), 64'(mq[pick[l]].s2));
         end
      end
      check_eq("free_count", 64'(free_count), 64'(nfree));
      check_eq("disp_stall", 64'(disp_stall), 64'(nfree < NW));
      if (flush) begin
         mq.delete();
      end else begin
         for (int i = 0; i < mq.size(); i++) begin
            iss = 1'b0;
            for (int l = 0; l < NW; l++) if (pick[l] == i) iss = 1'b1;
            if (!iss) begin
               e = mq[i];
               e.r1 = e.r1 | woken(e.s1);
               e.r2 = e.r2 | woken(e.s2);
               nq.push_back(e);
            end
         end
         if (nfree >= NW) begin
            for (int l = 0; l < NW; l++) begin
               if (disp_valid[l]) begin
                  e.inst = disp_inst[l*IB +: IB];
                  e.dest = disp_dest_tag[l*TB +: TB];
                  e.s1   = disp_src1_tag[l*TB +: TB];
                  e.s2   = disp_src2_tag[l*TB +: TB];
                  e.r1   = disp_src1_ready[l] | woken(e.s1);
                  e.r2   = disp_src2_ready[l] | woken(e.s2);
                  nq.push_back(e);
               end
            end
         end
         mq = nq;
      end
   endtask

   task automatic step();
      @(negedge clock);
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic [NW-1:0] fr);
      disp_valid = '0; disp_inst = '0; disp_dest_tag = '0;
      disp_src1_tag = '0; disp_src2_tag = '0;
      disp_src1_ready = '0; disp_src2_ready = '0;
      cdb_valid = '0; cdb_tag = '0; ex_valid = '0; ex_tag = '0;
      fu_ready = fr; flush = 1'b0;
   endtask

   task automatic disp(input int l, input logic [IB-1:0] inst, input logic [TB-1:0] dest,
                       input logic [TB-1:0] s1, input bit r1, input logic [TB-1:0] s2, input bit r2);
      disp_valid[l]            = 1'b1;
      disp_inst[l*IB +: IB]    = inst;
      disp_dest_tag[l*TB +: TB] = dest;
      disp_src1_tag[l*TB +: TB] = s1;
      disp_src2_tag[l*TB +: TB] = s2;
      disp_src1_ready[l]       = r1;
      disp_src2_ready[l]       = r2;
   endtask

   initial begin
      reset = 1'b1;
      idle(3'b111);
      #1 reset = 1'b0;
      #2;
      check_eq("rst_free", 64'(free_count), 64'd16);
      check_eq("rst_stall", 64'(disp_stall), 64'd0);
      check_eq("rst_issue", 64'(issue_valid), 64'd0);
      @(posedge clock);
      #1 reset = 1'b1;
      mq.delete();

      // Back-to-back dispatch and issue of three ready instructions
      idle(3'b111);
      disp(0, 32'h1000_0021, 6'd33, 6'd1, 1, 6'd2, 1);
      disp(1, 32'h1000_0022, 6'd34, 6'd3, 1, 6'd4, 1);
      disp(2, 32'h1000_0023, 6'd35, 6'd5, 1, 6'd6, 1);
      #1 check_eq("own_cycle_no_issue", 64'(issue_valid), 64'd0);
      step();
      idle(3'b111);
      #1;
      check_eq("basic_issue", 64'(issue_valid), 64'b111);
      check_eq("basic_dests", 64'(issue_dest_tag), 64'({6'd35, 6'd34, 6'd33}));
      check_eq("basic_free13", 64'(free_count), 64'd13);
      step();
      check_eq("basic_free16", 64'(free_count), 64'd16);

      // Wakeup latency for dest 36 waiting on tag 33
      idle(3'b111);
      disp(0, 32'h2000_0024, 6'd36, 6'd33, 0, 6'd7, 1);
      step();
      idle(3'b111);
`ifdef IQ_EARLY_WAKEUP_EN
      ex_valid[0] = 1'b1;
      ex_tag[TB-1:0] = 6'd33;
`endif
      #1 check_eq("wake_wait", 64'(issue_valid), 64'd0);
      step();
      idle(3'b111);
      cdb_valid[0] = 1'b1;
      cdb_tag[TB-1:0] = 6'd33;
      #1;
`ifdef IQ_EARLY_WAKEUP_EN
      check_eq("early_issue_t", 64'(issue_valid), 64'b001);
      check_eq("early_dest", 64'(issue_dest_tag[TB-1:0]), 64'd36);
      step();
      idle(3'b111);
      #1 check_eq("early_done", 64'(issue_valid), 64'd0);
`else
      check_eq("cdb_no_same", 64'(issue_valid), 64'd0);
      step();
      idle(3'b111);
      #1;
      check_eq("cdb_issue_t1", 64'(issue_valid), 64'b001);
      check_eq("cdb_dest", 64'(issue_dest_tag[TB-1:0]), 64'd36);
`endif
      step();

      // Fill with never-ready entries until dispatch stalls
      for (int g = 1; g <= 6; g++) begin
         idle(3'b111);
         for (int l = 0; l < NW; l++) disp(l, 32'h3000_0000 + 32'(g*4 + l), 6'(16 + g*3 + l), 6'd63, 0, 6'd63, 0);
         step();
         if (g == 5) begin
            check_eq("full_free1", 64'(free_count), 64'd1);
            check_eq("full_stall", 64'(disp_stall), 64'd1);
         end
      end
      check_eq("drop_free1", 64'(free_count), 64'd1);
      idle(3'b111);
      flush = 1'b1;
      step();
      check_eq("flush_free16", 64'(free_count), 64'd16);

      // Age order on a single lane after one shared wakeup
      idle(3'b001);
      disp(0, 32'h4000_0028, 6'd40, 6'd50, 0, 6'd8, 1);
      step();
      idle(3'b001);
      disp(0, 32'h4000_0029, 6'd41, 6'd50, 0, 6'd9, 1);
      disp(1, 32'h4000_002a, 6'd42, 6'd50, 0, 6'd10, 1);
      step();
      idle(3'b001);
      cdb_valid[2] = 1'b1;
      cdb_tag[2*TB +: TB] = 6'd50;
      step();
      for (int i = 0; i < 3; i++) begin
         idle(3'b001);
         #1;
         check_eq("age_valid", 64'(issue_valid), 64'b001);
         check_eq("age_dest", 64'(issue_dest_tag[TB-1:0]), 64'(40 + i));
         step();
      end
      check_eq("age_free16", 64'(free_count), 64'd16);

      // Flush beats dispatch and issue
      idle(3'b111);
      for (int l = 0; l < NW; l++) disp(l, 32'h5000_0000 + 32'(l), 6'(1 + l), 6'd0, 1, 6'd0, 1);
      step();
      idle(3'b111);
      for (int l = 0; l < NW; l++) disp(l, 32'h5100_0000 + 32'(l), 6'(4 + l), 6'd0, 1, 6'd0, 1);
      flush = 1'b1;
      #1 check_eq("flush_no_issue", 64'(issue_valid), 64'd0);
      step();
      idle(3'b111);
      #1;
      check_eq("flush_free", 64'(free_count), 64'd16);
      check_eq("flush_empty", 64'(issue_valid), 64'd0);

      // Random traffic with one asynchronous reset in the middle
      for (int cyc = 0; cyc < 3000; cyc++) begin
         idle(NW'($urandom));
         for (int l = 0; l < NW; l++) begin
            if ($urandom_range(0, 1) == 1)
               disp(l, $urandom, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 15)),
                    bit'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
            cdb_valid[l] = ($urandom_range(0, 3) == 0);
            cdb_tag[l*TB +: TB] = 6'($urandom_range(0, 15));
            ex_valid[l] = ($urandom_range(0, 3) == 0);
            ex_tag[l*TB +: TB] = 6'($urandom_range(0, 15));
         end
         flush = ($urandom_range(0, 63) == 0);
         if (cyc == 1500) begin
            reset = 1'b0;
            #1;
            check_eq("mid_rst_issue", 64'(issue_valid), 64'd0);
            check_eq("mid_rst_free", 64'(free_count), 64'd16);
            @(posedge clock);
            #1;
            check_eq("mid_rst_hold", 64'(issue_valid), 64'd0);
            check_eq("mid_rst_stall", 64'(disp_stall), 64'd0);
            reset = 1'b1;
            mq.delete();
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter N_WAY, default 3: dispatch, issue and CDB lanes per cycle.
REQ-002 SHALL have parameter N_ENTRIES, default 16: queue depth, N_ENTRIES >= N_WAY.
REQ-003 SHALL have parameter TAG_BITS, default 6: physical register tag width.
REQ-004 SHALL have parameter INST_BITS, default 32: instruction payload width.
REQ-005 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port disp_valid, input, N_WAY: per-lane dispatch request.
REQ-008 SHALL have port disp_inst, input, N_WAY*INST_BITS: instruction payload.
REQ-009 SHALL have port disp_dest_tag, input, N_WAY*TAG_BITS: destination tag.
REQ-010 SHALL have port disp_src1_tag, input, N_WAY*TAG_BITS: source 1 tag.
REQ-011 SHALL have port disp_src1_ready, input, N_WAY: source 1 already available.
REQ-012 SHALL have ports disp_src2_tag and disp_src2_ready, same widths and meaning as the source 1 ports.
REQ-013 SHALL have ports cdb_valid, input, N_WAY, and cdb_tag, input, N_WAY*TAG_BITS: completion broadcast.
REQ-014 SHALL have ports ex_valid, input, N_WAY, and ex_tag, input, N_WAY*TAG_BITS: execute-stage early-wakeup tags.
REQ-015 SHALL have port fu_ready, input, N_WAY: issue lane k may accept this cycle.
REQ-016 SHALL have port flush, input, 1: squash all entries.
REQ-017 SHALL have outputs issue_valid (N_WAY), issue_inst, issue_dest_tag, issue_src1_tag and issue_src2_tag (per-lane widths as for dispatch).
REQ-018 SHALL have output free_count, clog2(N_ENTRIES+1) bits: number of unoccupied entries.
REQ-019 SHALL have output disp_stall, 1 bit: set when free_count < N_WAY.

Function
REQ-020 SHALL accept all valid dispatch lanes only when disp_stall=0 and flush=0; otherwise it SHALL ignore every dispatch lane; there is no partial accept.
REQ-021 SHALL write accepted lanes into the lowest-index free entries, lane 0 first.
REQ-022 SHALL record dispatch age: lane 0 is older than lane 1, and earlier cycles are older than later ones.
REQ-023 SHALL set a source ready bit at the edge where any cdb_valid[j] lane has cdb_tag[j] equal to that source's tag.
REQ-024 SHALL apply the REQ-023 match to a same-cycle dispatch, so the source is written as ready.
REQ-025 SHALL treat an entry as issuable only when both registered ready bits are set; an entry is never issuable in its own dispatch cycle.
REQ-026 SHALL assign the i-th oldest issuable entry to the i-th lane having fu_ready=1, which makes issue_valid combinational from registered state.
REQ-027 SHALL free each entry whose lane has issue_valid=1 at the next edge.
REQ-028 SHALL make freed entries reusable, and reflect them in free_count, only from the following cycle.
REQ-029 SHALL have minimum latency of 1 cycle from dispatch edge to issue_valid, and 1 cycle from CDB edge to issue_valid.
REQ-030 SHALL give flush priority over dispatch, wakeup and issue: issue_valid is forced to 0 in the flush cycle, and all entries are cleared at the edge.
REQ-031 SHALL update free_count as: next = current - accepted + issued (all entries if flush), never wrapping.

Reset
REQ-032 SHALL, while reset=0, clear all entries and age state and force issue_valid=0, free_count=N_ENTRIES, disp_stall=0, independent of clock.
REQ-033 SHALL, when reset asserts mid-operation, discard all in-flight entries with no issue.

Configuration
REQ-034 SHALL, with IQ_EARLY_WAKEUP_EN defined, apply the ex_valid/ex_tag match exactly as the CDB match, waking consumers one cycle before CDB broadcast.
REQ-035 SHALL, without IQ_EARLY_WAKEUP_EN, keep the ex_valid and ex_tag ports present but ignore them.

Verification (N_WAY=3, N_ENTRIES=16)
REQ-036 SHALL check: reset low -> free_count=16, disp_stall=0, issue_valid=000.
REQ-037 SHALL check: dispatch dests 33/34/35, all sources ready, fu_ready=111 -> next cycle issue_valid=111 with dests 33,34,35 and free_count=13 -> following cycle free_count=16.
REQ-038 SHALL check: dispatch dest 36 with src1=33 not ready, cdb_tag 33 valid in cycle t -> dest 36 issues in t+1; with IQ_EARLY_WAKEUP_EN, ex_tag 33 in t-1 -> issues in t.
REQ-039 SHALL check: dispatch 3 never-ready entries per cycle for 6 cycles -> free_count=1 and disp_stall=1 after the 5th group; 6th group dropped; free_count stays 1.
REQ-040 SHALL check: dest 40 dispatched in cycle 1, dests 41/42 in cycle 2, all woken by one CDB tag, fu_ready=001 -> issue order 40, 41, 42 in consecutive cycles on lane 0.
REQ-041 SHALL check: flush together with 3 dispatches and 3 issuable entries -> issue_valid=000 that cycle, then free_count=16.
